wb_rr_arbiter: RTL and testbench

- N-master round-robin Wishbone arbiter with burst-aware grant hold and a bus watchdog.
- Sits between the CPU instruction/data ports, DMA and the external-bus bridge, and the single shared slave bus.
- Replaces fixed two-way priority selection with fair rotation.
- Aborts hung transfers with an error to the owning master.

---
 rtl/wb_rr_arbiter_if.sv | 46 ++++
 rtl/wb_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the round-robin Wishbone arbiter: the per-master request
// side, the shared slave side, and the grant/busy status.
// The arbiter uses the slave modport (it is the slave of every master);
// the master modport is the view of whatever drives the masters and slave.
interface wb_rr_arbiter_if #(
    parameter int N_MST  = 4,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [N_MST-1:0]        i_m_cyc;
    logic [N_MST-1:0]        i_m_stb;
    logic [N_MST*ADDR_W-1:0] i_m_adr;
    logic [N_MST*DATA_W-1:0] i_m_dat;
    logic [N_MST-1:0]        i_m_we;
    logic [2*N_MST-1:0]      i_m_sel;
    logic [N_MST-1:0]        i_m_8_burst;
    logic [N_MST-1:0]        i_m_4_burst;
    logic [N_MST-1:0]        o_m_ack;
    logic [N_MST-1:0]        o_m_err;
    logic                    o_cyc;
    logic                    o_stb;
    logic [ADDR_W-1:0]       o_adr;
    logic [DATA_W-1:0]       o_dat;
    logic                    o_we;
    logic [1:0]              o_sel;
    logic                    o_8_burst;
    logic                    o_4_burst;
    logic                    i_ack;
    logic                    i_err;
    logic [N_MST-1:0]        o_grant;
    logic                    o_busy;

    modport slave (
        input  i_m_cyc, i_m_stb, i_m_adr, i_m_dat, i_m_we, i_m_sel,
               i_m_8_burst, i_m_4_burst, i_ack, i_err,
        output o_m_ack, o_m_err, o_cyc, o_stb, o_adr, o_dat, o_we, o_sel,
               o_8_burst, o_4_burst, o_grant, o_busy
    );

    modport master (
        output i_m_cyc, i_m_stb, i_m_adr, i_m_dat, i_m_we, i_m_sel,
               i_m_8_burst, i_m_4_burst, i_ack, i_err,
        input  o_m_ack, o_m_err, o_cyc, o_stb, o_adr, o_dat, o_we, o_sel,
               o_8_burst, o_4_burst, o_grant, o_busy
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-master round-robin Wishbone arbiter. A granted master keeps the bus for
// as long as it holds cyc (bursts and stb gaps included); ownership then
// rotates starting after the previous owner. A watchdog aborts a transfer
// whose stb sits unanswered for TIMEOUT cycles and reports err to the owner.
module wb_rr_arbiter #(
    parameter int N_MST   = 4,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    wb_rr_arbiter_if.slave bus
);
    localparam int PTR_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_MST - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ERR   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [PTR_W-1:0]   ptr_r, ptr_s;
    logic [PTR_W-1:0]   owner_r, owner_s;
    logic [N_MST-1:0]   grant_r, grant_s;
    logic [7:0]         cnt_r, cnt_s;
    logic [PTR_W-1:0]   pick_s;
    logic               pick_vld_s;
    logic               own_cyc_s;
    logic               own_stb_s;
    logic               stall_s;
    logic [N_MST-1:0]   ack_s;
    logic [N_MST-1:0]   err_s;

    // Index of the master 'offs' positions after 'base', wrapping at N_MST.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        return PTR_W'((sum >= N_MST) ? (sum - N_MST) : sum);
    endfunction

    assign own_cyc_s   = bus.i_m_cyc[owner_r];
    assign own_stb_s   = bus.i_m_stb[owner_r];
    assign stall_s     = own_cyc_s & own_stb_s & ~bus.i_ack & ~bus.i_err;
    assign bus.o_m_ack = ack_s;
    assign bus.o_m_err = err_s;
    assign bus.o_grant = grant_r;
    assign bus.o_busy  = (state_r != ST_IDLE);

    // Round-robin scan: first requester after the last owner, using this cycle's cyc.
    always_comb begin
        pick_s     = '0;
        pick_vld_s = 1'b0;
        for (int i = 1; i <= N_MST; i++) begin
            if (!pick_vld_s && bus.i_m_cyc[rr_idx(ptr_r, i)]) begin
                pick_s     = rr_idx(ptr_r, i);
                pick_vld_s = 1'b1;
            end else begin
                pick_s     = pick_s;
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Mux the owner onto the slave bus and route slave responses back to the owner only.
    always_comb begin
        bus.o_cyc = 1'b0;
        bus.o_stb = 1'b0;
        ack_s     = '0;
        err_s     = '0;
        if (|grant_r) begin
            bus.o_adr     = bus.i_m_adr[int'(owner_r)*ADDR_W +: ADDR_W];
            bus.o_dat     = bus.i_m_dat[int'(owner_r)*DATA_W +: DATA_W];
            bus.o_we      = bus.i_m_we[owner_r];
            bus.o_sel     = bus.i_m_sel[int'(owner_r)*2 +: 2];
            bus.o_8_burst = bus.i_m_8_burst[owner_r];
            bus.o_4_burst = bus.i_m_4_burst[owner_r];
        end else begin
            bus.o_adr     = '0;
            bus.o_dat     = '0;
            bus.o_we      = 1'b0;
            bus.o_sel     = 2'b00;
            bus.o_8_burst = 1'b0;
            bus.o_4_burst = 1'b0;
        end
        case (state_r)
            ST_GRANT: begin
                bus.o_cyc      = own_cyc_s;
                bus.o_stb      = own_cyc_s & own_stb_s;
                ack_s[owner_r] = bus.i_ack;
                err_s[owner_r] = bus.i_err;
            end
            ST_ERR: begin
                err_s[owner_r] = 1'b1;
            end
            default: begin
                bus.o_cyc = 1'b0;
            end
        endcase
    end

    // Next-state logic: grant, hold while owner cyc is high, watchdog abort, drain.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        owner_s = owner_r;
        grant_s = grant_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 8'd0;
                if (pick_vld_s) begin
                    owner_s = pick_s;
                    grant_s = {{(N_MST-1){1'b0}}, 1'b1} << pick_s;
                    state_s = ST_GRANT;
                end else begin
                    grant_s = '0;
                end
            end
            ST_GRANT: begin
                if (!own_cyc_s) begin
                    ptr_s   = owner_r;
                    grant_s = '0;
                    cnt_s   = 8'd0;
                    state_s = ST_IDLE;
                end else if (stall_s) begin
                    if (cnt_r == TO_LAST) begin
                        cnt_s   = 8'd0;
                        state_s = ST_ERR;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = 8'd0;
                end
            end
            ST_ERR: begin
                state_s = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!own_cyc_s) begin
                    ptr_s   = owner_r;
                    grant_s = '0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                grant_s = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer, owner, grant and watchdog registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= PTR_INIT;
            owner_r <= '0;
            grant_r <= '0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            owner_r <= owner_s;
            grant_r <= grant_s;
            cnt_r   <= cnt_s;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: reset, rotation, burst hold, watchdog
// abort, slave error, and reset in the middle of a burst.
module tb_wb_rr_arbiter;
    logic i_clk;
    logic i_rst_n;
    int   n_cmp;
    int   n_bad;

    wb_rr_arbiter_if #(.N_MST(4), .ADDR_W(24), .DATA_W(16)) bus ();

    wb_rr_arbiter #(.N_MST(4), .ADDR_W(24), .DATA_W(16), .TIMEOUT(255)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic init_masters();
        for (int k = 0; k < 4; k++) begin
            bus.i_m_adr[k*24 +: 24] = 24'hA00000 + 24'(k);
            bus.i_m_dat[k*16 +: 16] = 16'hD000 + 16'(k);
            bus.i_m_sel[k*2 +: 2]   = 2'(k);
            bus.i_m_we[k]           = k[0];
        end
        bus.i_m_cyc     = 4'b0000;
        bus.i_m_stb     = 4'b0000;
        bus.i_m_8_burst = 4'b0000;
        bus.i_m_4_burst = 4'b0000;
        bus.i_ack       = 1'b0;
        bus.i_err       = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        init_masters();
        bus.i_m_cyc = 4'b1111;
        bus.i_m_stb = 4'b1111;
        bus.i_ack   = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        n_cmp++;
        if ({bus.o_cyc, bus.o_stb, bus.o_busy} !== 3'b000) begin
            n_bad++; $display("FAIL rst_cyc_stb_busy: got %b want 000", {bus.o_cyc, bus.o_stb, bus.o_busy});
        end
        n_cmp++;
        if (bus.o_grant !== 4'b0000) begin
            n_bad++; $display("FAIL rst_grant: got %b want 0000", bus.o_grant);
        end
        n_cmp++;
        if (bus.o_m_ack !== 4'b0000) begin
            n_bad++; $display("FAIL rst_ack: got %b want 0000", bus.o_m_ack);
        end
        n_cmp++;
        if (bus.o_adr !== 24'h000000) begin
            n_bad++; $display("FAIL rst_adr: got %h want 000000", bus.o_adr);
        end
        next_cycle();
        bus.i_ack = 1'b0;
        i_rst_n   = 1'b1;
        next_cycle();
        @(negedge i_clk);
        n_cmp++;
        if ({bus.o_grant, bus.o_cyc, bus.o_busy} !== {4'b0001, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL first_grant: got %b/%b/%b want 0001/1/1", bus.o_grant, bus.o_cyc, bus.o_busy);
        end
        n_cmp++;
        if (bus.o_adr !== 24'hA00000) begin
            n_bad++; $display("FAIL first_adr: got %h want a00000", bus.o_adr);
        end
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        for (int n = 0; n < 5; n++) begin
            int         e;
            logic [3:0] oh;
            e  = order[n];
            oh = 4'b0001 << e;
            // first beat
            next_cycle();
            bus.i_ack = 1'b1;
            @(negedge i_clk);
            n_cmp++;
            if ({bus.o_grant, bus.o_m_ack, bus.o_cyc} !== {oh, oh, 1'b1}) begin
                n_bad++; $display("FAIL rot_beat1 m%0d: got grant %b ack %b cyc %b want %b %b 1", e, bus.o_grant, bus.o_m_ack, bus.o_cyc, oh, oh);
            end
            n_cmp++;
            if (bus.o_adr !== 24'hA00000 + 24'(e)) begin
                n_bad++; $display("FAIL rot_adr m%0d: got %h want %h", e, bus.o_adr, 24'hA00000 + 24'(e));
            end
            // final beat, owner drops cyc with the ack
            next_cycle();
            bus.i_m_cyc[e] = 1'b0;
            bus.i_m_stb[e] = 1'b0;
            @(negedge i_clk);
            n_cmp++;
            if ({bus.o_m_ack, bus.o_cyc} !== {oh, 1'b0}) begin
                n_bad++; $display("FAIL rot_last m%0d: got ack %b cyc %b want %b 0", e, bus.o_m_ack, bus.o_cyc, oh);
            end
            // idle gap between owners
            next_cycle();
            bus.i_ack = 1'b0;
            if (n == 4) begin
                bus.i_m_cyc = 4'b0000;
                bus.i_m_stb = 4'b0000;
            end else begin
                bus.i_m_cyc[e] = 1'b1;
                bus.i_m_stb[e] = 1'b1;
            end
            @(negedge i_clk);
            n_cmp++;
            if ({bus.o_cyc, bus.o_grant, bus.o_busy} !== 6'b000000) begin
                n_bad++; $display("FAIL rot_gap m%0d: got cyc %b grant %b busy %b want 0 0000 0", e, bus.o_cyc, bus.o_grant, bus.o_busy);
            end
        end
        next_cycle();
        @(negedge i_clk);
        n_cmp++;
        if ({bus.o_grant, bus.o_busy} !== 5'b00000) begin
            n_bad++; $display("FAIL rot_idle: got grant %b busy %b want 0000 0", bus.o_grant, bus.o_busy);
        end
    endtask

    task automatic test_burst();
        int acks;
        acks = 0;
        bus.i_m_cyc     = 4'b0110;
        bus.i_m_stb     = 4'b0110;
        bus.i_m_8_burst = 4'b0010;
        next_cycle();
        @(negedge i_clk);
        n_cmp++;
        if ({bus.o_grant, bus.o_8_burst, bus.o_adr} !== {4'b0010, 1'b1, 24'hA00001}) begin
            n_bad++; $display("FAIL burst_grant: got %b %b %h want 0010 1 a00001", bus.o_grant, bus.o_8_burst, bus.o_adr);
        end
        for (int c = 0; c < 11; c++) begin
            logic gap;
            next_cycle();
            gap            = (c >= 4) && (c < 7);
            bus.i_m_stb[1] = !gap;
            bus.i_ack      = !gap;
            if (c == 10) begin
                bus.i_m_cyc[1] = 1'b0;
                bus.i_m_stb[1] = 1'b0;
            end else begin
                bus.i_m_cyc[1] = 1'b1;
            end
            @(negedge i_clk);
            if (bus.o_m_ack[1] === 1'b1) acks++;
            n_cmp++;
            if ({bus.o_grant, bus.o_m_ack} !== {4'b0010, (gap ? 4'b0000 : 4'b0010)}) begin
                n_bad++; $display("FAIL burst_hold c%0d: got grant %b ack %b want 0010 %b", c, bus.o_grant, bus.o_m_ack, (gap ? 4'b0000 : 4'b0010));
            end
        end
        n_cmp++;
        if (acks !== 8) begin
            n_bad++; $display("FAIL burst_acks: got %0d want 8", acks);
        end
        next_cycle();
        bus.i_ack       = 1'b0;
        bus.i_m_8_burst = 4'b0000;
        @(negedge i_clk);
        n_cmp++;
        if (bus.o_grant !== 4'b0000) begin
            n_bad++; $display("FAIL burst_release: got %b want 0000", bus.o_grant);
        end
        next_cycle();
        @(negedge i_clk);
        n_cmp++;
        if ({bus.o_grant, bus.o_cyc} !== {4'b0100, 1'b1}) begin
            n_bad++; $display("FAIL burst_next: got %b %b want 0100 1", bus.o_grant, bus.o_cyc);
        end
        next_cycle();
        bus.i_m_cyc = 4'b0000;
        bus.i_m_stb = 4'b0000;
        next_cycle();
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        bus.i_m_cyc = 4'b1001;
        bus.i_m_stb = 4'b1001;
        next_cycle();
        for (int i = 1; i <= 255; i++) begin
            @(negedge i_clk);
            if (bus.o_grant !== 4'b1000 || bus.o_cyc !== 1'b1 || bus.o_m_err !== 4'b0000) bad++;
            next_cycle();
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL wd_stall: got %0d bad cycles want 0", bad);
        end
        bus.i_ack = 1'b1;
        @(negedge i_clk);
        n_cmp++;
        if ({bus.o_m_err, bus.o_m_ack, bus.o_cyc, bus.o_stb, bus.o_busy} !== {4'b1000, 4'b0000, 3'b001}) begin
            n_bad++; $display("FAIL wd_err: got err %b ack %b cyc %b stb %b busy %b want 1000 0000 0 0 1", bus.o_m_err, bus.o_m_ack, bus.o_cyc, bus.o_stb, bus.o_busy);
        end
        next_cycle();
        bus.i_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            n_cmp++;
            if ({bus.o_m_err, bus.o_cyc, bus.o_busy, bus.o_grant} !== {4'b0000, 2'b01, 4'b1000}) begin
                n_bad++; $display("FAIL wd_drain%0d: got err %b cyc %b busy %b grant %b want 0000 0 1 1000", i, bus.o_m_err, bus.o_cyc, bus.o_busy, bus.o_grant);
            end
            next_cycle();
        end
        bus.i_m_cyc[3] = 1'b0;
        bus.i_m_stb[3] = 1'b0;
        next_cycle();
        @(negedge i_clk);
        n_cmp++;
        if ({bus.o_grant, bus.o_busy} !== 5'b00000) begin
            n_bad++; $display("FAIL wd_release: got %b %b want 0000 0", bus.o_grant, bus.o_busy);
        end
        next_cycle();
        @(negedge i_clk);
        n_cmp++;
        if (bus.o_grant !== 4'b0001) begin
            n_bad++; $display("FAIL wd_next: got %b want 0001", bus.o_grant);
        end
        next_cycle();
        bus.i_m_cyc = 4'b0000;
        bus.i_m_stb = 4'b0000;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_error();
        bus.i_m_cyc     = 4'b0110;
        bus.i_m_stb     = 4'b0110;
        bus.i_m_4_burst = 4'b0010;
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            bus.i_ack      = (c < 2);
            bus.i_err      = (c == 2);
            bus.i_m_stb[1] = (c < 3);
            @(negedge i_clk);
            n_cmp++;
            if ({bus.o_grant, bus.o_m_ack, bus.o_m_err, bus.o_cyc} !==
                {4'b0010, ((c < 2) ? 4'b0010 : 4'b0000), ((c == 2) ? 4'b0010 : 4'b0000), 1'b1}) begin
                n_bad++; $display("FAIL err_beat%0d: got grant %b ack %b err %b cyc %b", c, bus.o_grant, bus.o_m_ack, bus.o_m_err, bus.o_cyc);
            end
            if (c == 0) begin
                n_cmp++;
                if ({bus.o_adr, bus.o_dat, bus.o_we, bus.o_sel, bus.o_4_burst, bus.o_8_burst} !==
                    {24'hA00001, 16'hD001, 1'b1, 2'b01, 1'b1, 1'b0}) begin
                    n_bad++; $display("FAIL err_busmux: got %h %h %b %b %b %b want a00001 d001 1 01 1 0", bus.o_adr, bus.o_dat, bus.o_we, bus.o_sel, bus.o_4_burst, bus.o_8_burst);
                end
            end
        end
        next_cycle();
        bus.i_ack       = 1'b0;
        bus.i_err       = 1'b0;
        bus.i_m_cyc[1]  = 1'b0;
        bus.i_m_stb[1]  = 1'b0;
        bus.i_m_4_burst = 4'b0000;
        next_cycle();
        next_cycle();
        @(negedge i_clk);
        n_cmp++;
        if (bus.o_grant !== 4'b0100) begin
            n_bad++; $display("FAIL err_next: got %b want 0100", bus.o_grant);
        end
    endtask

    task automatic test_reset_mid();
        bus.i_m_8_burst = 4'b0100;
        next_cycle();
        bus.i_ack = 1'b1;
        @(negedge i_clk);
        n_cmp++;
        if (bus.o_m_ack !== 4'b0100) begin
            n_bad++; $display("FAIL rmid_ack: got %b want 0100", bus.o_m_ack);
        end
        #1;
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_m_ack, bus.o_cyc, bus.o_grant, bus.o_busy} !== 10'b0) begin
            n_bad++; $display("FAIL rmid_async: got ack %b cyc %b grant %b busy %b want all 0", bus.o_m_ack, bus.o_cyc, bus.o_grant, bus.o_busy);
        end
        bus.i_m_cyc = 4'b1111;
        bus.i_m_stb = 4'b1111;
        next_cycle();
        bus.i_ack = 1'b0;
        i_rst_n   = 1'b1;
        next_cycle();
        @(negedge i_clk);
        n_cmp++;
        if (bus.o_grant !== 4'b0001) begin
            n_bad++; $display("FAIL rmid_prio: got %b want 0001", bus.o_grant);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_rotation();
        test_burst();
        test_timeout();
        test_error();
        test_reset_mid();
        init_masters();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
